// File: rtl/pwm_sample_feeder.sv
// Sample FIFO feeding an 11-bit PWM stage at a fixed audio rate.
// Holds midscale while idle or starved; counts underruns.
module pwm_sample_feeder #(
    parameter int CLK_DIV = 2268,
    parameter int PREFILL = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [3:0]  volume,
    output logic [10:0] pwm_level,
    output logic        sample_tick,
    output logic [4:0]  fill,
    output logic [7:0]  underrun_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        STARVED = 2'd2
    } state_t;

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [4:0]    PF   = 5'(PREFILL);
    localparam logic [10:0]   MID  = 11'd1024;

    state_t state, state_nxt;

    logic [CW-1:0]     tick_cnt;
    logic [7:0]        mem [16];
    logic [3:0]        wr_ptr, rd_ptr;
    logic              push, pop;
    logic [3:0]        gain;
    logic signed [10:0] prod;
    logic [10:0]       level;

    assign sample_tick  = enable && (tick_cnt == LAST);
    assign sample_ready = (fill != 5'd16);
    assign push         = sample_valid && sample_ready;
    assign pop          = (state == PLAY) && sample_tick && (fill != 5'd0);

    // Product always lies in -1024..1016, so 11 bits hold it exactly.
    assign gain  = (volume > 4'd8) ? 4'd8 : volume;
    assign prod  = $signed({{3{mem[rd_ptr][7]}}, mem[rd_ptr]})
                 * $signed({7'd0, gain});
    assign level = unsigned'(prod) + MID;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (!enable || tick_cnt == LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 4'd1;
            if (pop)  rd_ptr <= rd_ptr + 4'd1;
            case ({push, pop})
                2'b10:   fill <= fill + 5'd1;
                2'b01:   fill <= fill - 5'd1;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (fill >= PF) state_nxt = PLAY;
                PLAY:    if (sample_tick && fill == 5'd0) state_nxt = STARVED;
                STARVED: if (fill >= PF) state_nxt = PLAY;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_level      <= MID;
            underrun_count <= '0;
        end else begin
            if (state != PLAY) begin
                pwm_level <= MID;
            end else if (sample_tick) begin
                pwm_level <= pop ? level : MID;
            end
            if (state == PLAY && state_nxt == STARVED
                && underrun_count != 8'hFF) begin
                underrun_count <= underrun_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Directed bench for pwm_sample_feeder.
// Short sample period keeps the run small.
module tb_pwm_sample_feeder;

    localparam int DIV = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [3:0]  volume;
    logic [10:0] pwm_level;
    logic        sample_tick;
    logic [4:0]  fill;
    logic [7:0]  underrun_count;

    int checks = 0;
    int errs   = 0;

    pwm_sample_feeder #(.CLK_DIV(DIV), .PREFILL(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .volume         (volume),
        .pwm_level      (pwm_level),
        .sample_tick    (sample_tick),
        .fill           (fill),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    // Advance through the next tick edge; bounded wait.
    task automatic tick_edge();
        int n = 0;
        while (!sample_tick && n < 200) begin
            step();
            n++;
        end
        chk("tick_seen", int'(sample_tick), 1);
        step();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int t;
        reset        = 1'b1;
        enable       = 1'b0;
        sample_in    = 8'h00;
        sample_valid = 1'b0;
        volume       = 4'd8;

        // Reset state
        do_reset();
        chk("rst_fill", int'(fill), 0);
        chk("rst_pwm", int'(pwm_level), 1024);
        chk("rst_under", int'(underrun_count), 0);
        chk("rst_ready", int'(sample_ready), 1);
        chk("rst_tick", int'(sample_tick), 0);
        chk("rst_state", int'(dut.state), 0);

        // Full-scale positive sample
        enable = 1'b1;
        for (int i = 0; i < 8; i++) push(8'h7F);
        step();
        chk("pf_state", int'(dut.state), 1);
        chk("pf_fill", int'(fill), 8);
        tick_edge();
        chk("max_pwm", int'(pwm_level), 2040);
        chk("max_fill", int'(fill), 7);

        // Gain and sign coverage
        do_reset();
        enable = 1'b1;
        volume = 4'd15;
        push(8'h80);
        push(8'h00);
        push(8'h05);
        push(8'hFD);
        for (int i = 0; i < 4; i++) push(8'h10);
        step();
        chk("g_state", int'(dut.state), 1);
        tick_edge();
        chk("neg_max", int'(pwm_level), 0);
        tick_edge();
        chk("zero", int'(pwm_level), 1024);
        volume = 4'd3;
        tick_edge();
        chk("pos_v3", int'(pwm_level), 1039);
        volume = 4'd4;
        tick_edge();
        chk("neg_v4", int'(pwm_level), 1012);
        volume = 4'd0;
        tick_edge();
        chk("vol0", int'(pwm_level), 1024);
        volume = 4'd8;
        tick_edge();
        chk("v8", int'(pwm_level), 1152);
        volume = 4'd1;
        for (int i = 0; i < 5; i++) step();
        chk("vol_hold", int'(pwm_level), 1152);

        // Full FIFO, blocked push, pop then refill
        do_reset();
        volume       = 4'd8;
        sample_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sample_in = 8'(i + 1);
            step();
        end
        chk("full_fill", int'(fill), 16);
        chk("full_ready", int'(sample_ready), 0);
        sample_in = 8'd17;
        step();
        chk("full_17th", int'(fill), 16);
        enable    = 1'b1;
        sample_in = 8'd99;
        step();
        chk("full_state", int'(dut.state), 1);
        tick_edge();
        chk("full_pop", int'(fill), 15);
        chk("full_pwm", int'(pwm_level), 1032);
        chk("full_rdy1", int'(sample_ready), 1);
        step();
        chk("full_refill", int'(fill), 16);
        sample_valid = 1'b0;

        // Underrun
        do_reset();
        enable = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        step();
        chk("u_state", int'(dut.state), 1);
        tick_edge();
        chk("u_t1", int'(pwm_level), 1032);
        for (int i = 0; i < 7; i++) tick_edge();
        chk("u_t8", int'(pwm_level), 1088);
        chk("u_empty", int'(fill), 0);
        tick_edge();
        chk("u_t9", int'(pwm_level), 1024);
        chk("u_starved", int'(dut.state), 2);
        chk("u_count", int'(underrun_count), 1);
        for (int i = 0; i < 8; i++) push(8'h10);
        step();
        chk("u_resume", int'(dut.state), 1);

        // Disable mid-play with fill=5
        for (int i = 0; i < 3; i++) tick_edge();
        chk("d_pwm", int'(pwm_level), 1152);
        chk("d_fill", int'(fill), 5);
        enable = 1'b0;
        step();
        chk("d_idle", int'(dut.state), 0);
        step();
        chk("d_mid", int'(pwm_level), 1024);
        chk("d_cnt", int'(dut.tick_cnt), 0);
        t = 0;
        for (int i = 0; i < 30; i++) begin
            t += int'(sample_tick);
            step();
        end
        chk("d_noticks", t, 0);
        chk("d_keep", int'(fill), 5);
        enable = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("re_idle", int'(dut.state), 0);
        chk("re_fill", int'(fill), 5);
        for (int i = 0; i < 3; i++) push(8'h20);
        chk("re_fill8", int'(fill), 8);
        step();
        chk("re_play", int'(dut.state), 1);

        // Asynchronous reset between edges
        enable = 1'b0;
        push(8'h01);
        push(8'h02);
        chk("ar_fill10", int'(fill), 10);
        chk("ar_under1", int'(underrun_count), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_fill", int'(fill), 0);
        chk("ar_pwm", int'(pwm_level), 1024);
        chk("ar_under", int'(underrun_count), 0);
        chk("ar_ready", int'(sample_ready), 1);
        chk("ar_state", int'(dut.state), 0);
        step();
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("post_idle", int'(dut.state), 0);
        chk("post_fill", int'(fill), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
